// File: rtl/lc3_arb_pkg.sv
// Shared types and requester ids for the LC-3 data-memory arbiter.
package lc3_arb_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE  = 2'd0,
    ARB_ISSUE = 2'd1,
    ARB_RESP  = 2'd2
  } arb_state_t;

  localparam logic REQ_CPU  = 1'b0;
  localparam logic REQ_HOST = 1'b1;

endpackage

// File: rtl/lc3_rr_pick2.sv
// Combinational two-way round-robin picker; pin restricts the choice to the last winner.
module lc3_rr_pick2 (
  input  logic [1:0] req,
  input  logic       last,
  input  logic       pin,
  output logic       valid,
  output logic       winner
);
  import lc3_arb_pkg::*;

  logic [1:0] eff;

  always_comb begin
    eff = req;
    if (pin) begin
      eff = (last == REQ_HOST) ? (req & 2'b10) : (req & 2'b01);
    end
    valid  = |eff;
    winner = (eff == 2'b11) ? ~last : eff[1];
  end

endmodule

// File: rtl/lc3_mem_arbiter.sv
// Two-requester arbiter for the single-port LC-3 data memory.
// Optional ownership lock: define ARB_LOCK_EN to add lock0/lock1.
//
// state     | meaning
// ARB_IDLE  | arbitrate; latch winner and its transaction
// ARB_ISSUE | drive memory from latches, pulse gnt of the winner
// ARB_RESP  | read data captured, pulse rvalid of the winner
module lc3_mem_arbiter #(
  parameter int AW = 16,
  parameter int DW = 16
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          req0,
  input  logic          we0,
  input  logic [AW-1:0] addr0,
  input  logic [DW-1:0] wdata0,
  output logic          gnt0,
  output logic          rvalid0,
  output logic [DW-1:0] rdata0,
  input  logic          req1,
  input  logic          we1,
  input  logic [AW-1:0] addr1,
  input  logic [DW-1:0] wdata1,
  output logic          gnt1,
  output logic          rvalid1,
  output logic [DW-1:0] rdata1,
`ifdef ARB_LOCK_EN
  input  logic          lock0,
  input  logic          lock1,
`endif
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  output logic          mem_we,
  input  logic [DW-1:0] mem_rdata
);
  import lc3_arb_pkg::*;

  arb_state_t    state_q, state_d;
  logic          win_q, win_d;
  logic          we_q, we_d;
  logic          last_q, last_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] wdata_q, wdata_d;
  logic [DW-1:0] rdata0_q, rdata0_d;
  logic [DW-1:0] rdata1_q, rdata1_d;
  logic          pick_valid, pick_winner, pick_pin;

`ifdef ARB_LOCK_EN
  logic pin_q, pin_d;
  logic lock_own, lock_win;

  // The pin owner is always the last winner, so only its lock matters.
  assign lock_own = (last_q == REQ_HOST) ? lock1 : lock0;
  assign lock_win = (win_q == REQ_HOST) ? lock1 : lock0;
  assign pick_pin = pin_q & lock_own;

  always_comb begin
    pin_d = pin_q;
    if (state_q == ARB_IDLE && !lock_own) pin_d = 1'b0;
    if (state_q == ARB_ISSUE)             pin_d = lock_win;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) pin_q <= 1'b0;
    else        pin_q <= pin_d;
  end
`else
  assign pick_pin = 1'b0;
`endif

  lc3_rr_pick2 u_pick (
    .req    ({req1, req0}),
    .last   (last_q),
    .pin    (pick_pin),
    .valid  (pick_valid),
    .winner (pick_winner)
  );

  always_comb begin
    state_d  = state_q;
    win_d    = win_q;
    we_d     = we_q;
    last_d   = last_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    rdata0_d = rdata0_q;
    rdata1_d = rdata1_q;
    case (state_q)
      ARB_IDLE: begin
        if (pick_valid) begin
          win_d   = pick_winner;
          last_d  = pick_winner;
          we_d    = (pick_winner == REQ_HOST) ? we1    : we0;
          addr_d  = (pick_winner == REQ_HOST) ? addr1  : addr0;
          wdata_d = (pick_winner == REQ_HOST) ? wdata1 : wdata0;
          state_d = ARB_ISSUE;
        end
      end
      ARB_ISSUE: begin
        state_d = we_q ? ARB_IDLE : ARB_RESP;
        if (!we_q) begin
          if (win_q == REQ_HOST) rdata1_d = mem_rdata;
          else                   rdata0_d = mem_rdata;
        end
      end
      ARB_RESP: state_d = ARB_IDLE;
      default:  state_d = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= ARB_IDLE;
      win_q    <= REQ_CPU;
      we_q     <= 1'b0;
      last_q   <= REQ_HOST;
      addr_q   <= '0;
      wdata_q  <= '0;
      rdata0_q <= '0;
      rdata1_q <= '0;
    end else begin
      state_q  <= state_d;
      win_q    <= win_d;
      we_q     <= we_d;
      last_q   <= last_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      rdata0_q <= rdata0_d;
      rdata1_q <= rdata1_d;
    end
  end

  // addr_q/wdata_q only change when entering ARB_ISSUE, so they hold the last issue.
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign mem_we    = (state_q == ARB_ISSUE) && we_q;
  assign gnt0      = (state_q == ARB_ISSUE) && (win_q == REQ_CPU);
  assign gnt1      = (state_q == ARB_ISSUE) && (win_q == REQ_HOST);
  assign rvalid0   = (state_q == ARB_RESP)  && (win_q == REQ_CPU);
  assign rvalid1   = (state_q == ARB_RESP)  && (win_q == REQ_HOST);
  assign rdata0    = rdata0_q;
  assign rdata1    = rdata1_q;

endmodule

// File: tb/tb_lc3_mem_arbiter.sv
// Directed bench for lc3_mem_arbiter; define ARB_LOCK_EN to also exercise the lock.
module tb_lc3_mem_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        req0, we0, req1, we1;
  logic [15:0] addr0, wdata0, addr1, wdata1;
  logic        gnt0, rvalid0, gnt1, rvalid1, mem_we;
  logic [15:0] rdata0, rdata1, mem_addr, mem_wdata, mem_rdata;
`ifdef ARB_LOCK_EN
  logic        lock0, lock1;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  lc3_mem_arbiter #(.AW(16), .DW(16)) dut (
    .clk(clk), .reset(reset),
    .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0),
    .gnt0(gnt0), .rvalid0(rvalid0), .rdata0(rdata0),
    .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1),
    .gnt1(gnt1), .rvalid1(rvalid1), .rdata1(rdata1),
`ifdef ARB_LOCK_EN
    .lock0(lock0), .lock1(lock1),
`endif
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we),
    .mem_rdata(mem_rdata)
  );

  // Memory model: combinational read, write at the rising edge; preload port for setup.
  logic [15:0] mem [0:255];
  logic        pl_en;
  logic [7:0]  pl_addr;
  logic [15:0] pl_data;
  assign mem_rdata = mem[mem_addr[7:0]];
  always @(posedge clk) begin
    if (pl_en)       mem[pl_addr] <= pl_data;
    else if (mem_we) mem[mem_addr[7:0]] <= mem_wdata;
  end

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%04h, want 0x%04h", name, act, exp);
    end
  endtask

  task automatic check1(input string name, input logic act, input logic exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %b, want %b", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_gnt(input int budget, input string name, output int who);
    who = -1;
    for (int c = 0; c < budget && who < 0; c++) begin
      tick();
      if (gnt0)      who = 0;
      else if (gnt1) who = 1;
    end
    if (who < 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL %s: no grant within %0d cycles", name, budget);
    end
  endtask

  // Exclusivity and requester-side stability, sampled at the falling edge.
  logic        free0, free1, preq0, preq1, pwe0, pwe1;
  logic [15:0] pa0, pa1, pd0, pd1;
  always @(negedge clk) begin
    if (!reset) begin
      free0 = 1'b0; free1 = 1'b0; preq0 = 1'b0; preq1 = 1'b0;
    end else begin
      check1("excl_gnt", gnt0 & gnt1, 1'b0);
      check1("excl_rvalid", rvalid0 & rvalid1, 1'b0);
      if (preq0 && req0 && !free0 && {we0, addr0, wdata0} != {pwe0, pa0, pd0}) begin
        n_bad++;
        $display("FAIL stable0: addr got 0x%04h, want 0x%04h (held until gnt0)", addr0, pa0);
      end
      if (preq1 && req1 && !free1 && {we1, addr1, wdata1} != {pwe1, pa1, pd1}) begin
        n_bad++;
        $display("FAIL stable1: addr got 0x%04h, want 0x%04h (held until gnt1)", addr1, pa1);
      end
      free0 = gnt0; free1 = gnt1;
      preq0 = req0; pwe0 = we0; pa0 = addr0; pd0 = wdata0;
      preq1 = req1; pwe1 = we1; pa1 = addr1; pd1 = wdata1;
    end
  end

  typedef struct {
    logic        r0, w0;
    logic [15:0] a0, d0;
    logic        r1, w1;
    logic [15:0] a1, d1;
    logic        g0, g1, v0, v1, mwe;
    logic [15:0] maddr, mwdata, rd0, rd1;
  } vec_t;

  function automatic vec_t mk(
    input logic r0, input logic w0, input logic [15:0] a0, input logic [15:0] d0,
    input logic r1, input logic w1, input logic [15:0] a1, input logic [15:0] d1,
    input logic g0, input logic g1, input logic v0, input logic v1, input logic mwe,
    input logic [15:0] maddr, input logic [15:0] mwdata,
    input logic [15:0] rd0, input logic [15:0] rd1);
    vec_t v;
    v.r0 = r0; v.w0 = w0; v.a0 = a0; v.d0 = d0;
    v.r1 = r1; v.w1 = w1; v.a1 = a1; v.d1 = d1;
    v.g0 = g0; v.g1 = g1; v.v0 = v0; v.v1 = v1; v.mwe = mwe;
    v.maddr = maddr; v.mwdata = mwdata; v.rd0 = rd0; v.rd1 = rd1;
    return v;
  endfunction

  vec_t vecs [11];

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int who;
    int n0, n1;
    logic [7:0]  pa [4];
    logic [15:0] pv [4];

    reset = 1'b0;
    req0 = 0; we0 = 0; addr0 = 0; wdata0 = 0;
    req1 = 0; we1 = 0; addr1 = 0; wdata1 = 0;
`ifdef ARB_LOCK_EN
    lock0 = 0; lock1 = 0;
`endif
    pa[0] = 8'h00; pv[0] = 16'h0000;
    pa[1] = 8'h40; pv[1] = 16'h1234;
    pa[2] = 8'h10; pv[2] = 16'h0000;
    pa[3] = 8'h30; pv[3] = 16'h0777;
    pl_en = 1'b0; pl_addr = 0; pl_data = 0;
    tick();
    for (int k = 0; k < 4; k++) begin
      pl_en = 1'b1; pl_addr = pa[k]; pl_data = pv[k];
      tick();
    end
    pl_en = 1'b0;

    check1("rst.gnt0", gnt0, 0);   check1("rst.gnt1", gnt1, 0);
    check1("rst.rvalid0", rvalid0, 0); check1("rst.rvalid1", rvalid1, 0);
    check1("rst.mem_we", mem_we, 0);
    check("rst.mem_addr", mem_addr, 16'h0); check("rst.mem_wdata", mem_wdata, 16'h0);
    check("rst.rdata0", rdata0, 16'h0);     check("rst.rdata1", rdata1, 16'h0);
    reset = 1'b1;

    //             r0 w0 a0       d0       r1 w1 a1       d1       g0 g1 v0 v1 we maddr    mwdata   rd0      rd1
    vecs[0]  = mk(1, 0, 16'h0040, 16'h0000, 0, 0, 16'h0000, 16'h0000, 1, 0, 0, 0, 0, 16'h0040, 16'h0000, 16'h0000, 16'h0000);
    vecs[1]  = mk(0, 0, 16'h0000, 16'h0000, 0, 0, 16'h0000, 16'h0000, 0, 0, 1, 0, 0, 16'h0040, 16'h0000, 16'h1234, 16'h0000);
    vecs[2]  = mk(0, 0, 16'h0000, 16'h0000, 0, 0, 16'h0000, 16'h0000, 0, 0, 0, 0, 0, 16'h0040, 16'h0000, 16'h1234, 16'h0000);
    vecs[3]  = mk(0, 0, 16'h0000, 16'h0000, 1, 1, 16'h0010, 16'hBEEF, 0, 1, 0, 0, 1, 16'h0010, 16'hBEEF, 16'h1234, 16'h0000);
    vecs[4]  = mk(0, 0, 16'h0000, 16'h0000, 0, 0, 16'h0000, 16'h0000, 0, 0, 0, 0, 0, 16'h0010, 16'hBEEF, 16'h1234, 16'h0000);
    vecs[5]  = mk(1, 0, 16'h0010, 16'h0000, 0, 0, 16'h0000, 16'h0000, 1, 0, 0, 0, 0, 16'h0010, 16'h0000, 16'h1234, 16'h0000);
    vecs[6]  = mk(0, 0, 16'h0000, 16'h0000, 0, 0, 16'h0000, 16'h0000, 0, 0, 1, 0, 0, 16'h0010, 16'h0000, 16'hBEEF, 16'h0000);
    vecs[7]  = mk(0, 0, 16'h0000, 16'h0000, 0, 0, 16'h0000, 16'h0000, 0, 0, 0, 0, 0, 16'h0010, 16'h0000, 16'hBEEF, 16'h0000);
    vecs[8]  = mk(0, 0, 16'h0000, 16'h0000, 1, 0, 16'h0040, 16'h0000, 0, 1, 0, 0, 0, 16'h0040, 16'h0000, 16'hBEEF, 16'h0000);
    vecs[9]  = mk(0, 0, 16'h0000, 16'h0000, 0, 0, 16'h0000, 16'h0000, 0, 0, 0, 1, 0, 16'h0040, 16'h0000, 16'hBEEF, 16'h1234);
    vecs[10] = mk(0, 0, 16'h0000, 16'h0000, 0, 0, 16'h0000, 16'h0000, 0, 0, 0, 0, 0, 16'h0040, 16'h0000, 16'hBEEF, 16'h1234);

    for (int i = 0; i < 11; i++) begin
      req0 = vecs[i].r0; we0 = vecs[i].w0; addr0 = vecs[i].a0; wdata0 = vecs[i].d0;
      req1 = vecs[i].r1; we1 = vecs[i].w1; addr1 = vecs[i].a1; wdata1 = vecs[i].d1;
      tick();
      check1($sformatf("vec%0d.gnt0", i), gnt0, vecs[i].g0);
      check1($sformatf("vec%0d.gnt1", i), gnt1, vecs[i].g1);
      check1($sformatf("vec%0d.rvalid0", i), rvalid0, vecs[i].v0);
      check1($sformatf("vec%0d.rvalid1", i), rvalid1, vecs[i].v1);
      check1($sformatf("vec%0d.mem_we", i), mem_we, vecs[i].mwe);
      check($sformatf("vec%0d.mem_addr", i), mem_addr, vecs[i].maddr);
      check($sformatf("vec%0d.mem_wdata", i), mem_wdata, vecs[i].mwdata);
      check($sformatf("vec%0d.rdata0", i), rdata0, vecs[i].rd0);
      check($sformatf("vec%0d.rdata1", i), rdata1, vecs[i].rd1);
    end

    // Contention: last winner was requester 1, so the order starts at 0.
    req0 = 1; we0 = 0; addr0 = 16'h0040; wdata0 = 0;
    req1 = 1; we1 = 0; addr1 = 16'h0010; wdata1 = 0;
    n0 = 0; n1 = 0;
    for (int i = 0; i < 8; i++) begin
      wait_gnt(6, $sformatf("fair%0d.wait", i), who);
      check($sformatf("fair%0d.winner", i), 16'(who), 16'(i % 2));
      if (who == 0) n0++;
      if (who == 1) n1++;
      tick();
      check1($sformatf("fair%0d.rvalid0", i), rvalid0, (i % 2) == 0);
      check1($sformatf("fair%0d.rvalid1", i), rvalid1, (i % 2) == 1);
      if (i % 2 == 0) check($sformatf("fair%0d.rdata0", i), rdata0, 16'h1234);
      else            check($sformatf("fair%0d.rdata1", i), rdata1, 16'hBEEF);
    end
    req0 = 0; req1 = 0;
    check("fair.count0", 16'(n0), 16'd4);
    check("fair.count1", 16'(n1), 16'd4);
    tick();

    // Back-to-back writes from requester 0: one grant every two cycles.
    for (int i = 0; i < 4; i++) begin
      req0 = 1; we0 = 1; addr0 = 16'h0020 + 16'(i); wdata0 = 16'hA000 + 16'(i);
      tick();
      check1($sformatf("b2b%0d.gnt0", i), gnt0, 1'b1);
      check1($sformatf("b2b%0d.mem_we", i), mem_we, 1'b1);
      check($sformatf("b2b%0d.mem_addr", i), mem_addr, 16'h0020 + 16'(i));
      check($sformatf("b2b%0d.mem_wdata", i), mem_wdata, 16'hA000 + 16'(i));
      if (i == 3) req0 = 0;
      tick();
      check1($sformatf("b2b%0d.gap_gnt0", i), gnt0, 1'b0);
      check1($sformatf("b2b%0d.gap_mem_we", i), mem_we, 1'b0);
    end
    for (int i = 0; i < 4; i++)
      check($sformatf("b2b%0d.mem", i), mem[8'h20 + 8'(i)], 16'hA000 + 16'(i));

    // Reset during ARB_ISSUE of a write; last winner is requester 0 at this point.
    req0 = 1; we0 = 1; addr0 = 16'h0030; wdata0 = 16'h5555;
    tick();
    check1("rmid.issue_we", mem_we, 1'b1);
    req0 = 0;
    #2 reset = 1'b0;
    #1;
    check1("rmid.mem_we", mem_we, 1'b0);
    check1("rmid.gnt0", gnt0, 1'b0);
    check1("rmid.rvalid0", rvalid0, 1'b0);
    check("rmid.mem_addr", mem_addr, 16'h0);
    check("rmid.mem_wdata", mem_wdata, 16'h0);
    check("rmid.rdata0", rdata0, 16'h0);
    check("rmid.rdata1", rdata1, 16'h0);
    tick();
    check("rmid.mem_untouched", mem[8'h30], 16'h0777);
    reset = 1'b1;
    req0 = 1; we0 = 0; addr0 = 16'h0040;
    req1 = 1; we1 = 0; addr1 = 16'h0010;
    tick();
    check1("rmid.first_gnt0", gnt0, 1'b1);
    check1("rmid.first_gnt1", gnt1, 1'b0);
    req0 = 0; req1 = 0;
    tick();
    tick();

`ifdef ARB_LOCK_EN
    // Host locks and issues 3 reads while the CPU keeps requesting.
    req0 = 1; we0 = 0; addr0 = 16'h0010;
    req1 = 1; we1 = 0; addr1 = 16'h0040;
    lock1 = 1;
    for (int i = 0; i < 3; i++) begin
      wait_gnt(6, $sformatf("lock%0d.wait", i), who);
      check($sformatf("lock%0d.winner", i), 16'(who), 16'd1);
      if (i == 2) lock1 = 0;
    end
    wait_gnt(6, "unlock.wait", who);
    check("unlock.winner", 16'(who), 16'd0);
    req0 = 0; req1 = 0;
    tick();
    tick();
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
